seg7_mux_decoder: RTL
=====================

Name: seg7_mux_decoder

Overview:
- Reads a multiplexed, active-low 7-segment bus (abcdefgh plus digit select) as driven by the board display scanners.
- Recovers the glyph shown on each digit and decodes it back to a hex nibble.
- Flags digits whose refresh has stopped.
- Used as an on-chip monitor/loopback checker for display drivers and as a bench observer in lab designs.

Parameters:
N_DIGITS, 4, number of multiplexed digits (width of digit bus)
STABLE_CYCLES, 8, consecutive identical samples required before a glyph is accepted (≥2)
TIMEOUT_CYCLES, 1048576, cycles without a capture after which a digit is marked stale

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
abcdefgh  input  8  segment bus, bit7=a … bit1=g, bit0=h(dp); 0 = lit
digit  input  N_DIGITS  digit select, active-low; bit i low selects digit i
glyph  output  8*N_DIGITS  last accepted raw byte per digit, digit i at [8i+7:8i]
hex  output  4*N_DIGITS  decoded nibble per digit
hex_valid  output  N_DIGITS  glyph a..g matches the hex table
dp  output  N_DIGITS  decimal point lit (glyph bit0 == 0)
fresh  output  N_DIGITS  digit captured within last TIMEOUT_CYCLES
update  output  N_DIGITS  one-cycle pulse: accepted glyph differs from previous
multi_sel  output  1  more than one digit selected (bus conflict)

Behaviour:
- Reset (async, reset_n=0): glyph all 8'hFF, hex 0, hex_valid 0, dp 0, fresh 0, update 0, multi_sel 0. Sample regs sd=all 1s, ss=8'hFF. Run counter rc=0. Timeout counters = TIMEOUT_CYCLES (stale). Reset mid-window discards the partial window.
- Sample stage: every edge sd<=digit, ss<=abcdefgh.
- Run counter, every edge:
  - if {digit,abcdefgh}=={sd,ss}: rc<=min(rc+1, STABLE_CYCLES)
  - else: rc<=0
- Capture:
  - Conditions on an edge: pins=={sd,ss}, rc==STABLE_CYCLES-1, and sd has exactly one zero bit at index i.
  - Action: glyph[i]<=ss; hex/hex_valid/dp[i] updated from ss on the same edge; timeout counter i<=0.
  - Net effect: pins held constant across edges k..k+STABLE_CYCLES give a capture at edge k+STABLE_CYCLES.
  - rc saturates, so a held pattern captures exactly once; a new capture requires a change.
- update[i]: high for the one cycle following the capture edge iff the new ss differs from the prior glyph[i], dp bit included. Otherwise 0.
- Select decoding:
  - digit all ones: idle, no capture, no error.
  - ≥2 zeros: no capture; multi_sel is registered from sd (high in cycles where sd has ≥2 zeros, one cycle behind the pins).
- Decode (ignore dp; compare ss[7:1] to lit pattern inverted), a..g lit (1=lit):
  - 0:1111110  1:0110000  2:1101101  3:1111001  4:0110011  5:1011011  6:1011111  7:1110000
  - 8:1111111  9:1111011  A:1110111  b:0011111  C:1001110  d:0111101  E:1001111  F:1000111
  - No match: hex=0, hex_valid=0.
  - Example: E with dp off = 8'b01100001.
- Timeout: per-digit counter, width clog2(TIMEOUT_CYCLES+1), increments each cycle, saturates at TIMEOUT_CYCLES. fresh[i]=(cnt_i<TIMEOUT_CYCLES). glyph retained when stale.
- Simultaneous capture and timeout saturation on the same edge: capture wins (cnt=0).
- Only one digit can be captured per edge.

Test Plan:
- Reset released, no stimulus for 20 cycles -> all glyph 8'hFF, fresh=0, hex_valid=0, multi_sel=0.
- digit=4'b1110, abcdefgh=8'b01100001 held 9 edges (STABLE_CYCLES=8) -> at edge 8: glyph[7:0]=8'h61, hex[3:0]=4'hE, hex_valid[0]=1, dp[0]=0; update[0] pulses once; holding 50 more cycles gives no further update.
- Pattern changed after only 7 edges -> no capture; glyph unchanged; update stays 0.
- Scan 4 digits as "8.21F" (each 8'b00000000, 8'b00100101, 8'b10011111, 8'b01110001), 64 cycles per digit, rotating -> hex=16'h821F, dp=4'b1000, hex_valid=4'hF, fresh=4'hF; update pulses only on the first pass.
- digit=4'b1100 for 10 cycles -> multi_sel=1 for 10 cycles (one-cycle lag), no glyph change. digit=4'b1111 -> multi_sel=0, no capture.
- TIMEOUT_CYCLES=100, capture digit 2 then stop scanning -> fresh[2] falls exactly 100 cycles after the capture edge, glyph[2] retained. Assert reset_n=0 mid-window -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/seg7_mux_decoder.sv
// Observes a multiplexed active-low 7-segment bus, recovers the stable glyph on each
// digit, decodes it to a hex nibble and tracks how recently each digit was refreshed.
module seg7_mux_decoder #(
  parameter int N_DIGITS       = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            abcdefgh,
  input  logic [N_DIGITS-1:0]   digit,
  output logic [8*N_DIGITS-1:0] glyph,
  output logic [4*N_DIGITS-1:0] hex,
  output logic [N_DIGITS-1:0]   hex_valid,
  output logic [N_DIGITS-1:0]   dp,
  output logic [N_DIGITS-1:0]   fresh,
  output logic [N_DIGITS-1:0]   update,
  output logic                  multi_sel
);

  localparam int RC_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(STABLE_CYCLES);
  localparam logic [RC_W-1:0] RC_ARM = RC_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  function automatic int unsigned count_zeros(input logic [N_DIGITS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!v[i]) n++;
    end
    return n;
  endfunction

  // Returns {valid, nibble}; input is segments a..g as driven (0 = lit).
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg_n);
    logic [6:0] lit;
    lit = ~seg_n;
    case (lit)
      7'b1111110: return 5'h10;
      7'b0110000: return 5'h11;
      7'b1101101: return 5'h12;
      7'b1111001: return 5'h13;
      7'b0110011: return 5'h14;
      7'b1011011: return 5'h15;
      7'b1011111: return 5'h16;
      7'b1110000: return 5'h17;
      7'b1111111: return 5'h18;
      7'b1111011: return 5'h19;
      7'b1110111: return 5'h1A;
      7'b0011111: return 5'h1B;
      7'b1001110: return 5'h1C;
      7'b0111101: return 5'h1D;
      7'b1001111: return 5'h1E;
      7'b1000111: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  logic [N_DIGITS-1:0] sd_q;
  logic [7:0]          ss_q;
  logic [RC_W-1:0]     rc_q, rc_d;
  logic                multi_sel_q;
  logic                pins_match;
  logic [N_DIGITS-1:0] cap_vec;
  logic [4:0]          dec;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rc_d       = '0;
    cap_vec    = '0;
    pins_match = ({digit, abcdefgh} == {sd_q, ss_q});
    dec        = decode_glyph(ss_q[7:1]);
    if (pins_match) begin
      rc_d = (rc_q == RC_MAX) ? RC_MAX : rc_q + 1'b1;
    end
    // A saturated run never returns to RC_ARM, so a held pattern captures only once.
    if (pins_match && (rc_q == RC_ARM) && (count_zeros(sd_q) == 1)) begin
      cap_vec = ~sd_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sd_q        <= '1;
      ss_q        <= 8'hFF;
      rc_q        <= '0;
      multi_sel_q <= 1'b0;
    end else begin
      sd_q        <= digit;
      ss_q        <= abcdefgh;
      rc_q        <= rc_d;
      // Computed from the pins on the same edge sd_q loads them, so it always mirrors sd_q.
      multi_sel_q <= (count_zeros(digit) >= 2);
    end
  end

  assign multi_sel = multi_sel_q;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    logic [7:0]      glyph_q;
    logic [3:0]      hex_q;
    logic            hex_valid_q;
    logic            dp_q;
    logic            update_q;
    logic [TO_W-1:0] to_q, to_d;

    always_comb begin
      to_d = to_q;
      if (cap_vec[gi]) begin
        to_d = '0;
      end else if (to_q != TO_MAX) begin
        to_d = to_q + 1'b1;
      end
    end

    // NOTE: the per-digit glyph registers are reset explicitly; the monitor must show blanks, not X.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        glyph_q     <= 8'hFF;
        hex_q       <= 4'h0;
        hex_valid_q <= 1'b0;
        dp_q        <= 1'b0;
        update_q    <= 1'b0;
        to_q        <= TO_MAX;
      end else begin
        update_q <= 1'b0;
        if (cap_vec[gi]) begin
          glyph_q     <= ss_q;
          hex_q       <= dec[3:0];
          hex_valid_q <= dec[4];
          dp_q        <= ~ss_q[0];
          update_q    <= (ss_q != glyph_q);
        end
        to_q <= to_d;
      end
    end

    assign glyph[8*gi +: 8] = glyph_q;
    assign hex[4*gi +: 4]   = hex_q;
    assign hex_valid[gi]    = hex_valid_q;
    assign dp[gi]           = dp_q;
    assign update[gi]       = update_q;
    assign fresh[gi]        = (to_q < TO_MAX);
  end

endmodule
